// File: rtl/prefix_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : prefix_adder_pipe_if
// Description : Operand/result handshake bundle for prefix_adder_pipe.
//               Upstream side: in_valid/in_ready, a, b, cin (and sub when
//               PREFIX_SUB_EN is defined).
//               Downstream side: out_valid/out_ready, sum, cout.
//               modport slave  : the adder
//               modport master : the agent driving operands / taking results
// Macro       : PREFIX_SUB_EN adds the subtract-select signal sub
// Revision    : 1.0  initial release
// ============================================================================
interface prefix_adder_pipe_if #(
  parameter int WIDTH = 66
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PREFIX_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef PREFIX_SUB_EN
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
`else
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : prefix_adder_pipe
// Description : Pipelined Kogge-Stone parallel-prefix adder, sum = a + b + cin.
//               log2(WIDTH) prefix levels, a register slice after every
//               PIPE_EVERY levels and always after the last level, with
//               valid/ready flow control that absorbs bubbles.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - prefix_adder_pipe_if.slave (operands in, result out)
// Parameters  : WIDTH (>=2), PIPE_EVERY (1..levels)
// Macro       : PREFIX_SUB_EN - computes a + ~b + (cin ^ sub) when sub = 1
// Revision    : 1.0  initial release
// ============================================================================
module prefix_adder_pipe #(
  parameter int WIDTH      = 66,
  parameter int PIPE_EVERY = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  prefix_adder_pipe_if.slave bus
);

  localparam int c_levels = $clog2(WIDTH);
  localparam int c_lat    = (c_levels + PIPE_EVERY - 1) / PIPE_EVERY;

  // --------------------------------------------------------------------------
  // Level 0: bitwise propagate/generate, carry-in folded into g[0]
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;

`ifdef PREFIX_SUB_EN
  assign w_b_eff   = bus.b ^ {WIDTH{bus.sub}};
  assign w_cin_eff = bus.cin ^ bus.sub;
`else
  assign w_b_eff   = bus.b;
  assign w_cin_eff = bus.cin;
`endif

  always_comb begin
    w_p0    = bus.a ^ w_b_eff;
    w_g0    = bus.a & w_b_eff;
    w_g0[0] = w_g0[0] | (w_p0[0] & w_cin_eff);
  end

  // --------------------------------------------------------------------------
  // Flow control: slice j loads when it is empty or everything downstream of
  // it moves, i.e. load[j] = out_ready | any empty slice at index >= j.
  // --------------------------------------------------------------------------
  logic [c_lat-1:0] r_v;
  logic [c_lat-1:0] w_load;
  logic             w_load_acc;

  always_comb begin
    w_load_acc = bus.out_ready;
    w_load     = '0;
    for (int j = c_lat - 1; j >= 0; j--) begin
      w_load_acc = w_load_acc | ~r_v[j];
      w_load[j]  = w_load_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      if (w_load[0]) r_v[0] <= bus.in_valid;
      for (int j = 1; j < c_lat; j++) begin
        if (w_load[j]) r_v[j] <= r_v[j-1];
      end
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_v[c_lat-1];

  // --------------------------------------------------------------------------
  // Prefix levels. The input of level k comes from level 0, from a slice
  // register (when level k-1 closes a slice) or straight from level k-1.
  // P is not needed after the last level, so that level only produces G.
  // --------------------------------------------------------------------------
  for (genvar k = 1; k <= c_levels; k++) begin : g_lvl
    localparam int c_span    = 1 << (k - 1);
    localparam int c_src     = (k - 1 + PIPE_EVERY - 1) / PIPE_EVERY - 1;
    localparam bit c_src_reg = (k > 1) && (((k - 1) % PIPE_EVERY) == 0);

    logic [WIDTH-1:0] w_gi;
    logic [WIDTH-1:0] w_pi;
    logic [WIDTH-1:0] w_go;

    if (k == 1) begin : g_from_in
      assign w_gi = w_g0;
      assign w_pi = w_p0;
    end else if (c_src_reg) begin : g_from_reg
      assign w_gi = g_slc[c_src].r_g;
      assign w_pi = g_slc[c_src].g_p.r_p;
    end else begin : g_from_comb
      assign w_gi = g_lvl[k-1].w_go;
      assign w_pi = g_lvl[k-1].g_p.w_po;
    end

    always_comb begin
      w_go = w_gi;
      for (int i = c_span; i < WIDTH; i++) begin
        w_go[i] = w_gi[i] | (w_pi[i] & w_gi[i-c_span]);
      end
    end

    if (k < c_levels) begin : g_p
      logic [WIDTH-1:0] w_po;
      always_comb begin
        w_po = w_pi;
        for (int i = c_span; i < WIDTH; i++) begin
          w_po[i] = w_pi[i] & w_pi[i-c_span];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register slices. Each carries the group G/P after its closing level plus
  // the original bitwise p and the effective carry-in for the final XOR.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < c_lat; j++) begin : g_slc
    localparam int c_lvl = ((j + 1) * PIPE_EVERY > c_levels) ? c_levels
                                                             : (j + 1) * PIPE_EVERY;

    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_po;
    logic             r_cin;
    logic [WIDTH-1:0] w_po_up;
    logic             w_cin_up;

    if (j == 0) begin : g_first
      assign w_po_up  = w_p0;
      assign w_cin_up = w_cin_eff;
    end else begin : g_next
      assign w_po_up  = g_slc[j-1].r_po;
      assign w_cin_up = g_slc[j-1].r_cin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_g   <= '0;
        r_po  <= '0;
        r_cin <= 1'b0;
      end else if (w_load[j]) begin
        r_g   <= g_lvl[c_lvl].w_go;
        r_po  <= w_po_up;
        r_cin <= w_cin_up;
      end
    end

    if (j < c_lat - 1) begin : g_p
      logic [WIDTH-1:0] r_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p <= '0;
        end else if (w_load[j]) begin
          r_p <= g_lvl[c_lvl].g_p.w_po;
        end
      end
    end
  end

  // Carry into bit i is the group generate of bits i-1..0 (cin already folded
  // into g[0]); bit 0 takes the raw carry-in. All-zero registers give sum = 0.
  assign bus.sum  = g_slc[c_lat-1].r_po ^ {g_slc[c_lat-1].r_g[WIDTH-2:0],
                                           g_slc[c_lat-1].r_cin};
  assign bus.cout = g_slc[c_lat-1].r_g[WIDTH-1];

endmodule
`default_nettype wire
